control: RTL and testbench



---
 rtl/control.sv | 91 +++++++++
 tb/tb_control.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/control.sv
// Main control decoder for the single-issue MIPS datapath.
// Decodes the 6-bit opcode into registered datapath steering signals (one-cycle latency).
module control (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  output logic       o_RegDst,
  output logic [1:0] o_ALUOp,
  output logic       o_ALUSrc,
  output logic       o_Branch,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_RegWrite,
  output logic       o_MemtoReg
);

  localparam logic [5:0] OP_RFORMAT = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  logic       reg_dst_d;
  logic [1:0] alu_op_d;
  logic       alu_src_d;
  logic       branch_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       reg_write_d;
  logic       mem_to_reg_d;

  // Unknown opcodes (including X/Z) fall to the all-zero bubble.
  always_comb begin
    reg_dst_d    = 1'b0;
    alu_op_d     = ALU_ADD;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    case (i_opcode)
      OP_RFORMAT: begin
        reg_dst_d   = 1'b1;
        alu_op_d    = ALU_FUNCT;
        reg_write_d = 1'b1;
      end
      OP_LW: begin
        alu_src_d    = 1'b1;
        mem_read_d   = 1'b1;
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      OP_SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_BEQ: begin
        alu_op_d = ALU_SUB;
        branch_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_RegDst   <= 1'b0;
      o_ALUOp    <= ALU_ADD;
      o_ALUSrc   <= 1'b0;
      o_Branch   <= 1'b0;
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_RegWrite <= 1'b0;
      o_MemtoReg <= 1'b0;
    end else begin
      o_RegDst   <= reg_dst_d;
      o_ALUOp    <= alu_op_d;
      o_ALUSrc   <= alu_src_d;
      o_Branch   <= branch_d;
      o_MemRead  <= mem_read_d;
      o_MemWrite <= mem_write_d;
      o_RegWrite <= reg_write_d;
      o_MemtoReg <= mem_to_reg_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// Randomized self-checking bench for the control decoder against a behavioural
// model built from instruction semantics.
module tb_control;

  logic       i_clk;
  logic       i_rst_n;
  logic [5:0] i_opcode;
  logic       o_RegDst;
  logic [1:0] o_ALUOp;
  logic       o_ALUSrc;
  logic       o_Branch;
  logic       o_MemRead;
  logic       o_MemWrite;
  logic       o_RegWrite;
  logic       o_MemtoReg;

  int errors = 0;
  int checks = 0;

  control dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_opcode  (i_opcode),
    .o_RegDst  (o_RegDst),
    .o_ALUOp   (o_ALUOp),
    .o_ALUSrc  (o_ALUSrc),
    .o_Branch  (o_Branch),
    .o_MemRead (o_MemRead),
    .o_MemWrite(o_MemWrite),
    .o_RegWrite(o_RegWrite),
    .o_MemtoReg(o_MemtoReg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [8:0] observed();
    return {o_RegDst, o_ALUOp, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite, o_RegWrite, o_MemtoReg};
  endfunction

  // Reference: derive each control line from what the instruction class does.
  function automatic logic [8:0] model(input logic [5:0] op);
    bit is_r, is_lw, is_sw, is_beq;
    logic [1:0] alu;
    is_r   = (op == 6'd0);
    is_lw  = (op == 6'd35);
    is_sw  = (op == 6'd43);
    is_beq = (op == 6'd4);
    alu = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
    return {is_r, alu, (is_lw | is_sw), is_beq, is_lw, is_sw, (is_r | is_lw), is_lw};
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic checkInvariants(input string tag);
    checkOutput({tag, "_rd_wr"}, {8'd0, o_MemRead & o_MemWrite}, 9'd0);
    checkOutput({tag, "_wr_rw"}, {8'd0, o_MemWrite & o_RegWrite}, 9'd0);
    checkOutput({tag, "_br"}, {8'd0, o_Branch & (o_RegWrite | o_MemWrite)}, 9'd0);
  endtask

  // Drive an opcode at the falling edge, then check one step after the rising edge.
  task automatic applyStimulus(input string tag, input logic [5:0] op);
    @(negedge i_clk);
    i_opcode = op;
    @(posedge i_clk);
    #1;
    checkOutput(tag, observed(), model(op));
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] undef_ops [3];
    logic [5:0] legal_ops [4];
    undef_ops = '{6'b000010, 6'b001000, 6'b111111};
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100};

    i_rst_n  = 1'b0;
    i_opcode = 6'b000000;
    #1;
    checkOutput("reset_async", observed(), 9'd0);
    repeat (3) begin
      @(posedge i_clk);
      #1;
      checkOutput("reset_hold", observed(), 9'd0);
      checkInvariants("reset");
    end

    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("reset_release", observed(), 9'b1_10_0_0_0_0_1_0);

    // Each legal opcode held for two edges, against fixed expected rows.
    for (int k = 0; k < 2; k++) begin
      applyStimulus("seq_rformat", 6'b000000);
      checkOutput("row_rformat", observed(), 9'b1_10_0_0_0_0_1_0);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus("seq_lw", 6'b100011);
      checkOutput("row_lw", observed(), 9'b0_00_1_0_1_0_1_1);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus("seq_sw", 6'b101011);
      checkOutput("row_sw", observed(), 9'b0_00_1_0_0_1_0_0);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus("seq_beq", 6'b000100);
      checkOutput("row_beq", observed(), 9'b0_01_0_1_0_0_0_0);
    end

    for (int k = 0; k < 3; k++) begin
      applyStimulus("undef", undef_ops[k]);
      checkOutput("undef_zero", observed(), 9'd0);
    end

    // Asynchronous reset between edges clears outputs before the next edge.
    applyStimulus("pre_reset_lw", 6'b100011);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_async", observed(), 9'd0);
    repeat (2) begin
      @(posedge i_clk);
      #1;
      checkOutput("mid_reset_hold", observed(), 9'd0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus("post_reset_lw", 6'b100011);

    // Opcode change just after an edge must not reach outputs until the next edge.
    applyStimulus("lat_lw", 6'b100011);
    i_opcode = 6'b101011;
    #3;
    checkOutput("lat_hold_lw", observed(), 9'b0_00_1_0_1_0_1_1);
    @(posedge i_clk);
    #1;
    checkOutput("lat_sw", observed(), 9'b0_00_1_0_0_1_0_0);

    for (int k = 0; k < 64; k++) begin
      applyStimulus("sweep", 6'(k));
      checkInvariants("sweep");
    end

    // Random opcodes biased toward legal ones, with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 0)
        op = legal_ops[$urandom_range(0, 3)];
      else
        op = 6'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        @(negedge i_clk);
        i_opcode = op;
        i_rst_n  = 1'b0;
        #1;
        checkOutput("rand_reset", observed(), 9'd0);
        @(posedge i_clk);
        #1;
        checkOutput("rand_reset_edge", observed(), 9'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
      end else begin
        applyStimulus("rand", op);
      end
      checkInvariants("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
